// File: rtl/universal_shift_ctrl_pkg.sv
// Shared definitions for the universal shift register controller:
// register mode encodings, command opcodes and the sequencer state type.
package universal_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  function automatic logic [1:0] shift_mode(input logic [1:0] op);
    return (op == OP_SHR) ? MODE_SHR : MODE_SHL;
  endfunction

endpackage

// File: rtl/universal_shift_ctrl_counter.sv
// Loadable down-counter tracking the remaining shift steps; saturates at zero.
module shift_step_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/universal_shift_ctrl.sv
// Command sequencer for a universal shift register: one load or N-step
// shift/rotate per handshake, then a done pulse carrying the final contents.
module universal_shift_ctrl
  import universal_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  input  logic             cmd_rot,
  input  logic             abort,
  input  logic [WIDTH-1:0] A,
  output logic [1:0]       s,
  output logic [WIDTH-1:0] i,
  output logic             SR,
  output logic             SL,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] result
);

  state_t           state_q, state_d;
  logic [1:0]       s_q, s_d;
  logic [WIDTH-1:0] i_q, i_d;
  logic [1:0]       op_q, op_d;
  logic             fill_q, fill_d;
  logic             rot_q, rot_d;
  logic             pend_q, pend_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt;

  shift_step_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cmd_count),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // s/i are computed from the next state so the registered mode lines up
  // with the cycle the FSM spends in LOAD/SHIFT. done/aborted/result are
  // registered on the edge leaving DONE, once A holds the final value.
  always_comb begin
    state_d   = state_q;
    s_d       = MODE_HOLD;
    i_d       = '0;
    op_d      = op_q;
    fill_d    = fill_q;
    rot_d     = rot_q;
    pend_d    = pend_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    result_d  = result_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (cmd_valid) begin
          op_d     = cmd_op;
          fill_d   = cmd_fill;
          rot_d    = cmd_rot;
          cnt_load = 1'b1;
          if (cmd_op == OP_LOAD) begin
            state_d = LOAD;
            s_d     = MODE_LOAD;
            i_d     = cmd_data;
          end else if ((cmd_op == OP_RSVD) || (cmd_count == '0)) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
            s_d     = shift_mode(cmd_op);
          end
        end
      end
      LOAD: begin
        state_d = DONE;
        pend_d  = abort;
      end
      SHIFT: begin
        cnt_dec = 1'b1;
        if (abort) begin
          state_d = DONE;
          pend_d  = 1'b1;
        end else if ((cnt == CNT_W'(1)) || cnt_zero) begin
          state_d = DONE;
        end else begin
          s_d = shift_mode(op_q);
        end
      end
      DONE: begin
        state_d   = IDLE;
        done_d    = 1'b1;
        aborted_d = pend_q;
        result_d  = A;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      s_q       <= MODE_HOLD;
      i_q       <= '0;
      op_q      <= '0;
      fill_q    <= 1'b0;
      rot_q     <= 1'b0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      i_q       <= i_d;
      op_q      <= op_d;
      fill_q    <= fill_d;
      rot_q     <= rot_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      result_q  <= result_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign s         = s_q;
  assign i         = i_q;
  assign SR        = (state_q == SHIFT) && (rot_q ? A[0] : fill_q);
  assign SL        = (state_q == SHIFT) && (rot_q ? A[WIDTH-1] : fill_q);
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign result    = result_q;

endmodule

// File: tb/tb_universal_shift_ctrl.sv
// Directed bench for universal_shift_ctrl driving a behavioural 4-bit
// universal shift register; expected values are hand-computed constants.
module tb_universal_shift_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [2:0] cmd_count;
  logic       cmd_fill, cmd_rot, abort;
  logic [3:0] a_reg = '0;
  logic [1:0] s;
  logic [3:0] i;
  logic       SR, SL, busy, done, aborted;
  logic [3:0] result;

  int n_checks = 0;
  int n_err    = 0;

  int lat, n_shr, n_shl, n_load, acc;
  logic seen;

  universal_shift_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_count (cmd_count),
    .cmd_fill  (cmd_fill),
    .cmd_rot   (cmd_rot),
    .abort     (abort),
    .A         (a_reg),
    .s         (s),
    .i         (i),
    .SR        (SR),
    .SL        (SL),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .result    (result)
  );

  always #5 clk = ~clk;

  // Controlled universal shift register
  always @(posedge clk) begin
    case (s)
      2'b01:   a_reg <= {SR, a_reg[3:1]};
      2'b10:   a_reg <= {a_reg[2:0], SL};
      2'b11:   a_reg <= i;
      default: a_reg <= a_reg;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issues one command, scrambles cmd_* after accept, and returns at the
  // negedge where done is seen (lat = edges after the accept edge).
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] data,
                         input logic [2:0] cnt, input logic fill, input logic rot,
                         input int abort_at, output int lat_o, output int shr_o,
                         output int shl_o, output int load_o);
    lat_o = -1; shr_o = 0; shl_o = 0; load_o = 0;
    @(negedge clk);
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_op = op; cmd_data = data; cmd_count = cnt; cmd_fill = fill; cmd_rot = rot;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = ~op; cmd_data = ~data; cmd_count = ~cnt; cmd_fill = ~fill; cmd_rot = ~rot;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat_o = k;
        break;
      end
      abort = (k == abort_at);
      case (s)
        2'b01: shr_o++;
        2'b10: shl_o++;
        2'b11: load_o++;
        default: ;
      endcase
    end
    abort = 1'b0;
  endtask

  task automatic expect_cmd(input string tag, input int e_lat, input logic [3:0] e_res,
                            input logic e_ab, input int e_shr, input int e_shl, input int e_load);
    chk({tag, "_latency"}, lat, e_lat);
    chk({tag, "_result"}, result, e_res);
    chk({tag, "_A"}, a_reg, e_res);
    chk({tag, "_aborted"}, aborted, e_ab);
    chk({tag, "_shr_cycles"}, n_shr, e_shr);
    chk({tag, "_shl_cycles"}, n_shl, e_shl);
    chk({tag, "_load_cycles"}, n_load, e_load);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_result_hold"}, result, e_res);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_count = '0;
    cmd_fill = 1'b0; cmd_rot = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_s", s, 0);
    chk("rst_i", i, 0);
    chk("rst_sr_sl", {SR, SL}, 0);
    chk("rst_done", {done, aborted}, 0);
    chk("rst_result", result, 0);
    reset = 1'b0;

    run_cmd(2'b00, 4'hA, 3'd0, 1'b0, 1'b0, -1, lat, n_shr, n_shl, n_load);
    expect_cmd("load_a", 2, 4'hA, 1'b0, 0, 0, 1);

    run_cmd(2'b00, 4'b1011, 3'd0, 1'b0, 1'b0, -1, lat, n_shr, n_shl, n_load);
    expect_cmd("load_b", 2, 4'b1011, 1'b0, 0, 0, 1);
    run_cmd(2'b01, 4'h0, 3'd2, 1'b0, 1'b0, -1, lat, n_shr, n_shl, n_load);
    expect_cmd("shr2_fill0", 3, 4'b0010, 1'b0, 2, 0, 0);
    run_cmd(2'b00, 4'b1011, 3'd0, 1'b0, 1'b0, -1, lat, n_shr, n_shl, n_load);
    expect_cmd("load_b2", 2, 4'b1011, 1'b0, 0, 0, 1);
    run_cmd(2'b10, 4'h0, 3'd3, 1'b1, 1'b0, -1, lat, n_shr, n_shl, n_load);
    expect_cmd("shl3_fill1", 4, 4'b1111, 1'b0, 0, 3, 0);

    run_cmd(2'b00, 4'b0001, 3'd0, 1'b0, 1'b0, -1, lat, n_shr, n_shl, n_load);
    expect_cmd("load_1", 2, 4'b0001, 1'b0, 0, 0, 1);
    run_cmd(2'b01, 4'h0, 3'd1, 1'b0, 1'b1, -1, lat, n_shr, n_shl, n_load);
    expect_cmd("shr1_rot", 2, 4'b1000, 1'b0, 1, 0, 0);
    run_cmd(2'b10, 4'h0, 3'd4, 1'b0, 1'b1, -1, lat, n_shr, n_shl, n_load);
    expect_cmd("shl4_rot", 5, 4'b1000, 1'b0, 0, 4, 0);

    run_cmd(2'b01, 4'h0, 3'd0, 1'b1, 1'b0, -1, lat, n_shr, n_shl, n_load);
    expect_cmd("count0", 1, 4'b1000, 1'b0, 0, 0, 0);
    run_cmd(2'b11, 4'h5, 3'd5, 1'b1, 1'b0, -1, lat, n_shr, n_shl, n_load);
    expect_cmd("op_rsvd", 1, 4'b1000, 1'b0, 0, 0, 0);

    run_cmd(2'b00, 4'b0000, 3'd0, 1'b0, 1'b0, -1, lat, n_shr, n_shl, n_load);
    expect_cmd("load_0", 2, 4'b0000, 1'b0, 0, 0, 1);
    run_cmd(2'b01, 4'h0, 3'd7, 1'b1, 1'b0, 2, lat, n_shr, n_shl, n_load);
    expect_cmd("shr7_abort", 4, 4'b1110, 1'b1, 3, 0, 0);

    // Reset in the middle of a shift
    @(negedge clk);
    cmd_op = 2'b01; cmd_count = 3'd5; cmd_fill = 1'b1; cmd_rot = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    chk("mid_busy", busy, 1);
    chk("mid_s", s, 2'b01);
    chk("mid_ready", cmd_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstmid_s", s, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_ready", cmd_ready, 1);
    chk("rstmid_done", done, 0);
    chk("rstmid_result", result, 0);
    cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | done;
    end
    chk("rstmid_no_done", seen, 0);

    // cmd_valid held across a whole command: exactly one accept
    run_cmd(2'b00, 4'b0011, 3'd0, 1'b0, 1'b0, -1, lat, n_shr, n_shl, n_load);
    expect_cmd("load_3", 2, 4'b0011, 1'b0, 0, 0, 1);
    @(negedge clk);
    cmd_op = 2'b10; cmd_count = 3'd2; cmd_fill = 1'b0; cmd_rot = 1'b0; cmd_valid = 1'b1;
    acc = cmd_ready ? 1 : 0;
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
      lat++;
      if (cmd_ready) acc++;
    end
    cmd_valid = 1'b0;
    chk("hold_accepts", acc, 1);
    chk("hold_busy_cycles", lat, 3);
    chk("hold_done", done, 1);
    chk("hold_result", result, 4'b1100);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
